// File: rtl/universal_shift_match.sv
// Universal shift register (hold / shift right / shift left / load) with a
// pattern-match edge detector and a saturating match counter.
module universal_shift_match #(
  parameter int unsigned             WIDTH   = 8,
  parameter logic [WIDTH-1:0]        PATTERN = WIDTH'('hA5),
  parameter int unsigned             CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             ser_msb,
  input  logic             ser_lsb,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic             eq;
  logic             eq_prev;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    q_next = q;
    if (en) begin
      case (mode)
        MODE_HOLD: q_next = q;
        MODE_SHR:  q_next = {ser_msb, q[WIDTH-1:1]};
        MODE_SHL:  q_next = {q[WIDTH-2:0], ser_lsb};
        MODE_LOAD: q_next = din;
        default:   q_next = q;
      endcase
    end
  end

  assign eq       = (q == PATTERN);
  assign match    = eq & ~eq_prev;
  assign cnt_sat  = &match_cnt;
  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];

  // eq_prev resets to 1 so a reset value equal to PATTERN never pulses match
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q         <= '0;
      eq_prev   <= 1'b1;
      match_cnt <= '0;
    end else begin
      q       <= q_next;
      eq_prev <= eq;
      if (clr_cnt)
        match_cnt <= '0;
      else if (match && !cnt_sat)
        match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule
